// File: rtl/tappu_pkg.sv
// tappu_pkg: shared types, pin width and slice helper for the core mux.
//   state_t   switch-over sequencer states
//   PIN_W     width of one TinyTapeout pin group
//   slice8    picks core k's 8-bit lane from a packed per-core bus
package tappu_pkg;
   typedef enum logic [1:0] {INIT, RUN, QUIESCE, CORE_RST} state_t;
   localparam int PIN_W = 8;
   localparam int MAX_CORES = 16;
   localparam int MAX_BUS_W = MAX_CORES * PIN_W;
   function automatic logic [PIN_W-1:0] slice8(input logic [MAX_BUS_W-1:0] bus, input logic [3:0] k);
      logic [6:0] base;
      base = {k, 3'b000};
      return bus[base +: PIN_W];
   endfunction
endpackage

// File: rtl/tappu_sync.sv
// tappu_sync: multi-stage flop synchroniser with synchronous reset to 0.
//   clock, reset  clock and active-high synchronous reset
//   d             asynchronous input
//   q             output of the last stage
module tappu_sync #(
   parameter int W      = 1,
   parameter int STAGES = 2
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [STAGES-1:0][W-1:0] ff;
   always_ff @(posedge clock) begin
      if (reset) ff <= '0;
      else ff <= {ff[STAGES-2:0], d};
   end
   assign q = ff[STAGES-1];
endmodule

// File: rtl/tappu_core_mux.sv
// tappu_core_mux: hosts NUM_CORES cores behind one pin set with a clean switch-over.
//   clock, reset                     clock and active-high synchronous reset
//   io_ui_in, io_uio_in              pin inputs, broadcast as core_ui_in / core_uio_in
//   sel_in                           asynchronous core select
//   io_uo_out, io_uio_out, io_uio_oe registered pin outputs of the active core
//   core_reset                       per-core reset, only the running core released
//   core_uo_out/uio_out/uio_oe       packed core outputs, core k at [8k+7:8k]
//   active_sel                       core currently owning the pins
//   busy                             high in INIT, QUIESCE and CORE_RST
module tappu_core_mux
   import tappu_pkg::*;
#(
   parameter int NUM_CORES     = 4,
   parameter int SEL_W         = 4,
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 8,
   parameter int RST_CYCLES    = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [PIN_W-1:0]           io_ui_in,
   input  logic [PIN_W-1:0]           io_uio_in,
   input  logic [SEL_W-1:0]           sel_in,
   output logic [PIN_W-1:0]           io_uo_out,
   output logic [PIN_W-1:0]           io_uio_out,
   output logic [PIN_W-1:0]           io_uio_oe,
   output logic [PIN_W-1:0]           core_ui_in,
   output logic [PIN_W-1:0]           core_uio_in,
   output logic [NUM_CORES-1:0]       core_reset,
   input  logic [NUM_CORES*PIN_W-1:0] core_uo_out,
   input  logic [NUM_CORES*PIN_W-1:0] core_uio_out,
   input  logic [NUM_CORES*PIN_W-1:0] core_uio_oe,
   output logic [SEL_W-1:0]           active_sel,
   output logic                       busy
);
   localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
   localparam int RCNT_W = $clog2(RST_CYCLES + 1);
   state_t state, state_nxt;
   logic [SEL_W-1:0] sel_sync, last_sel, pending_sel, active_nxt, pending_nxt;
   logic [STAB_W-1:0] stab_cnt, stab_nxt;
   logic [RCNT_W-1:0] rst_cnt, rst_nxt;
   logic act_ok, load;
   tappu_sync #(.W(SEL_W), .STAGES(SYNC_STAGES)) u_sync (
      .clock(clock),
      .reset(reset),
      .d(sel_in),
      .q(sel_sync)
   );
   assign core_ui_in  = io_ui_in;
   assign core_uio_in = io_uio_in;
   assign act_ok      = 32'(active_sel) < NUM_CORES;
   assign busy        = state != RUN;
   assign core_reset  = (state == RUN && act_ok) ? ~(NUM_CORES'(1) << active_sel) : '1;
   // Pins only carry core data while RUN continues, so the edge entering QUIESCE already clears them.
   assign load        = state == RUN && state_nxt == RUN && act_ok;
   always_comb begin
      state_nxt   = state;
      active_nxt  = active_sel;
      pending_nxt = pending_sel;
      stab_nxt    = '0;
      rst_nxt     = '0;
      case (state)
         INIT: begin
            // Track sel_sync through INIT so the synchroniser has flushed its reset zeros by RUN.
            active_nxt = sel_sync;
            rst_nxt    = rst_cnt + 1'b1;
            if (rst_cnt == RCNT_W'(RST_CYCLES - 1)) begin
               state_nxt = RUN;
               rst_nxt   = '0;
            end
         end
         RUN: begin
            // A fresh select value restarts the count at 1; matching the active core clears it.
            stab_nxt = (sel_sync == active_sel) ? '0 :
                       (sel_sync != last_sel) ? STAB_W'(1) : stab_cnt + 1'b1;
            if (stab_nxt == STAB_W'(STABLE_CYCLES)) begin
               state_nxt   = QUIESCE;
               pending_nxt = sel_sync;
               stab_nxt    = '0;
            end
         end
         QUIESCE: begin
            active_nxt = pending_sel;
            state_nxt  = CORE_RST;
         end
         CORE_RST: begin
            rst_nxt = rst_cnt + 1'b1;
            if (rst_cnt == RCNT_W'(RST_CYCLES - 1)) begin
               state_nxt = RUN;
               rst_nxt   = '0;
            end
         end
         default: state_nxt = INIT;
      endcase
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= INIT;
         active_sel  <= '0;
         pending_sel <= '0;
         last_sel    <= '0;
         stab_cnt    <= '0;
         rst_cnt     <= '0;
         io_uo_out   <= '0;
         io_uio_out  <= '0;
         io_uio_oe   <= '0;
      end else begin
         state       <= state_nxt;
         active_sel  <= active_nxt;
         pending_sel <= pending_nxt;
         last_sel    <= sel_sync;
         stab_cnt    <= stab_nxt;
         rst_cnt     <= rst_nxt;
         io_uo_out   <= load ? slice8(MAX_BUS_W'(core_uo_out), 4'(active_sel)) : '0;
         io_uio_out  <= load ? slice8(MAX_BUS_W'(core_uio_out), 4'(active_sel)) : '0;
         io_uio_oe   <= load ? slice8(MAX_BUS_W'(core_uio_oe), 4'(active_sel)) : '0;
      end
   end
endmodule
